srl_dly_ctrl: RTL

- Controller that sequences a bank of cascaded 16-deep dynamic-address shift-register delay lines (Stages x 16 taps, Width bits each).
- Converts a requested delay in clocks into a per-stage tap address, a stage-output select and a shift enable.
- Gates an output-valid flag until the line has refilled after any delay change.
- Sits between the slow-control register interface and the data-path delay lines, e.g. L1A and data-valid alignment.

---
 rtl/srl_dly_ctrl.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/srl_dly_ctrl.sv
// Sequencer for a bank of cascaded 16-deep shift-register delay lines: delay request -> tap/stage select, refill gating.
// Optional macro SRL_DLY_FLUSH_EN adds a FLUSH output, high while the line refills.
module srl_dly_ctrl #(
  parameter int Stages = 2,
  parameter int DW     = 7
) (
  input  logic          CLK,
  input  logic          RST_N,
  input  logic          EN,
  input  logic          DLY_REQ,
  input  logic [DW-1:0] DLY,
  output logic          ACK,
  output logic          ERR,
  output logic          BUSY,
  output logic          SRL_CE,
  output logic [3:0]    SRL_A,
  output logic [2:0]    SRL_SEL,
  output logic [DW-1:0] CUR_DLY,
  output logic          OUT_VLD
`ifdef SRL_DLY_FLUSH_EN
  ,
  output logic          FLUSH
`endif
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_FILL = 2'd2,
    S_RUN  = 2'd3
  } state_t;

  localparam logic [DW-1:0] MAX_DLY = DW'(16 * Stages - 1);
  localparam logic [DW:0]   CNT_ONE = (DW + 1)'(1);

  state_t          r_state;
  logic [DW-1:0]   r_dly_lat;
  logic [DW:0]     r_fill_cnt;
  logic            r_ack;
  logic            r_err;
  logic            r_busy;
  logic [3:0]      r_srl_a;
  logic [2:0]      r_srl_sel;
  logic [DW-1:0]   r_cur_dly;
  logic            r_out_vld;
  logic            r_flush;

  state_t          w_state_nxt;
  logic [DW-1:0]   w_dly_lat_nxt;
  logic [DW:0]     w_fill_cnt_nxt;
  logic            w_ack_nxt;
  logic            w_err_nxt;
  logic            w_busy_nxt;
  logic [3:0]      w_srl_a_nxt;
  logic [2:0]      w_srl_sel_nxt;
  logic [DW-1:0]   w_cur_dly_nxt;
  logic            w_out_vld_nxt;
  logic            w_flush_nxt;
  logic            w_req_ok;
  logic [DW-1:0]   w_dly_stage;

  assign w_req_ok    = (DLY <= MAX_DLY);
  assign w_dly_stage = r_dly_lat >> 4;

  // Shift enable is combinational so the line and the fill counter stall on the same edge.
  assign SRL_CE = ((r_state == S_FILL) || (r_state == S_RUN)) ? EN : 1'b0;

  // Next-state and next-output computation.
  always_comb begin
    w_state_nxt    = r_state;
    w_dly_lat_nxt  = r_dly_lat;
    w_fill_cnt_nxt = r_fill_cnt;
    w_ack_nxt      = 1'b0;
    w_err_nxt      = 1'b0;
    w_busy_nxt     = r_busy;
    w_srl_a_nxt    = r_srl_a;
    w_srl_sel_nxt  = r_srl_sel;
    w_cur_dly_nxt  = r_cur_dly;
    w_out_vld_nxt  = r_out_vld;

    case (r_state)
      S_IDLE: begin
        if (DLY_REQ && w_req_ok) begin
          w_ack_nxt     = 1'b1;
          w_busy_nxt    = 1'b1;
          w_dly_lat_nxt = DLY;
          w_state_nxt   = S_LOAD;
        end else if (EN) begin
          w_err_nxt      = DLY_REQ;
          w_busy_nxt     = 1'b1;
          w_fill_cnt_nxt = {1'b0, r_cur_dly} + CNT_ONE;
          w_state_nxt    = S_FILL;
        end else begin
          w_err_nxt = DLY_REQ;
        end
      end
      S_LOAD: begin
        w_err_nxt      = DLY_REQ;
        w_srl_a_nxt    = r_dly_lat[3:0];
        w_srl_sel_nxt  = 3'(w_dly_stage);
        w_cur_dly_nxt  = r_dly_lat;
        w_fill_cnt_nxt = {1'b0, r_dly_lat} + CNT_ONE;
        w_out_vld_nxt  = 1'b0;
        w_state_nxt    = S_FILL;
      end
      S_FILL: begin
        w_err_nxt = DLY_REQ;
        // Counter sits at 1 on the last fill edge; OUT_VLD registers on that same edge.
        if (EN && (r_fill_cnt <= CNT_ONE)) begin
          w_fill_cnt_nxt = '0;
          w_out_vld_nxt  = 1'b1;
          w_busy_nxt     = 1'b0;
          w_state_nxt    = S_RUN;
        end else if (EN) begin
          w_fill_cnt_nxt = r_fill_cnt - CNT_ONE;
        end else begin
          w_fill_cnt_nxt = r_fill_cnt;
        end
      end
      S_RUN: begin
        if (DLY_REQ && w_req_ok) begin
          w_ack_nxt     = 1'b1;
          w_busy_nxt    = 1'b1;
          w_dly_lat_nxt = DLY;
          w_state_nxt   = S_LOAD;
        end else begin
          w_err_nxt = DLY_REQ;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    w_flush_nxt = (w_state_nxt == S_FILL);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_state    <= S_IDLE;
      r_dly_lat  <= '0;
      r_fill_cnt <= '0;
      r_ack      <= 1'b0;
      r_err      <= 1'b0;
      r_busy     <= 1'b0;
      r_srl_a    <= 4'd0;
      r_srl_sel  <= 3'd0;
      r_cur_dly  <= '0;
      r_out_vld  <= 1'b0;
      r_flush    <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_dly_lat  <= w_dly_lat_nxt;
      r_fill_cnt <= w_fill_cnt_nxt;
      r_ack      <= w_ack_nxt;
      r_err      <= w_err_nxt;
      r_busy     <= w_busy_nxt;
      r_srl_a    <= w_srl_a_nxt;
      r_srl_sel  <= w_srl_sel_nxt;
      r_cur_dly  <= w_cur_dly_nxt;
      r_out_vld  <= w_out_vld_nxt;
      r_flush    <= w_flush_nxt;
    end
  end

  assign ACK     = r_ack;
  assign ERR     = r_err;
  assign BUSY    = r_busy;
  assign SRL_A   = r_srl_a;
  assign SRL_SEL = r_srl_sel;
  assign CUR_DLY = r_cur_dly;
  assign OUT_VLD = r_out_vld;

`ifdef SRL_DLY_FLUSH_EN
  assign FLUSH = r_flush;
`else
  logic w_flush_unused;
  assign w_flush_unused = r_flush;
`endif

endmodule
